register_file_core: RTL and testbench

- 32 x 32-bit RISC-V integer register file storage for Stage2 (decode).
- Directly feeds the read-port 32:1 selection: holds the 32 architectural registers and drives them into two mux32to1 instances, one per read port.
- Accepts the write-back port from Stage5 and provides write-to-read bypass, so a same-cycle write is visible to decode.

---
 rtl/rf_pkg.sv | 11 +
 rtl/decoder5to32.sv | 19 +
 rtl/mux32to1.sv | 23 ++
 rtl/register_file_core.sv | 73 +++++++
 tb/tb_register_file_core.sv | 137 +++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the RV32 integer register file.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;

  typedef logic [XLEN-1:0]           reg_word_t;
  typedef reg_word_t [NREG-1:0]      reg_array_t;
endpackage

// File: rtl/decoder5to32.sv
// Write-port decoder: one-hot register write enable, x0 never enabled.
// Purely combinational; no flow control.
module decoder5to32
  import rf_pkg::*;
(
  input  logic            reg_write,
  input  logic [AW-1:0]   wr_addr,
  output logic [NREG-1:0] wr_en
);

  always_comb begin
    wr_en = '0;
    if (reg_write && (wr_addr != ZERO_REG)) begin
      wr_en[wr_addr] = 1'b1;
    end
    wr_en[0] = 1'b0;
  end

endmodule

// File: rtl/mux32to1.sv
// 32:1 word selector; Sel=k routes input X(k+1) to Y.
// Purely combinational; no flow control.
module mux32to1
  import rf_pkg::*;
(
  input  reg_word_t       X1,  X2,  X3,  X4,  X5,  X6,  X7,  X8,
  input  reg_word_t       X9,  X10, X11, X12, X13, X14, X15, X16,
  input  reg_word_t       X17, X18, X19, X20, X21, X22, X23, X24,
  input  reg_word_t       X25, X26, X27, X28, X29, X30, X31, X32,
  input  logic [AW-1:0]   Sel,
  output reg_word_t       Y
);

  reg_array_t xs;

  assign xs = {X32, X31, X30, X29, X28, X27, X26, X25,
               X24, X23, X22, X21, X20, X19, X18, X17,
               X16, X15, X14, X13, X12, X11, X10, X9,
               X8,  X7,  X6,  X5,  X4,  X3,  X2,  X1};

  assign Y = xs[Sel];

endmodule

// File: rtl/register_file_core.sv
// 32x32 RV32 register file: x0 hardwired to zero, two read ports with write-to-read bypass.
// Reads are zero-latency combinational, writes land on the next rising CLK; no backpressure.
module register_file_core
  import rf_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            RegWrite,
  input  logic [AW-1:0]   WrAddr,
  input  logic [XLEN-1:0] WrData,
  input  logic [AW-1:0]   RdAddr1,
  input  logic [AW-1:0]   RdAddr2,
  output logic [XLEN-1:0] RdData1,
  output logic [XLEN-1:0] RdData2
);

  logic [NREG-1:0] wr_en;
  reg_word_t       regs_q [1:NREG-1];
  reg_word_t       regs_d [1:NREG-1];
  reg_word_t       mux_y1, mux_y2;
  logic            byp1, byp2;

  decoder5to32 u_dec (
    .reg_write (RegWrite),
    .wr_addr   (WrAddr),
    .wr_en     (wr_en)
  );

  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = wr_en[i] ? WrData : regs_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 1; i < NREG; i++) begin
      regs_q[i] <= RST_n ? regs_d[i] : '0;
    end
  end

  mux32to1 u_mux1 (
    .X1 ('0),         .X2 (regs_q[1]),  .X3 (regs_q[2]),  .X4 (regs_q[3]),
    .X5 (regs_q[4]),  .X6 (regs_q[5]),  .X7 (regs_q[6]),  .X8 (regs_q[7]),
    .X9 (regs_q[8]),  .X10(regs_q[9]),  .X11(regs_q[10]), .X12(regs_q[11]),
    .X13(regs_q[12]), .X14(regs_q[13]), .X15(regs_q[14]), .X16(regs_q[15]),
    .X17(regs_q[16]), .X18(regs_q[17]), .X19(regs_q[18]), .X20(regs_q[19]),
    .X21(regs_q[20]), .X22(regs_q[21]), .X23(regs_q[22]), .X24(regs_q[23]),
    .X25(regs_q[24]), .X26(regs_q[25]), .X27(regs_q[26]), .X28(regs_q[27]),
    .X29(regs_q[28]), .X30(regs_q[29]), .X31(regs_q[30]), .X32(regs_q[31]),
    .Sel(RdAddr1),    .Y  (mux_y1)
  );

  mux32to1 u_mux2 (
    .X1 ('0),         .X2 (regs_q[1]),  .X3 (regs_q[2]),  .X4 (regs_q[3]),
    .X5 (regs_q[4]),  .X6 (regs_q[5]),  .X7 (regs_q[6]),  .X8 (regs_q[7]),
    .X9 (regs_q[8]),  .X10(regs_q[9]),  .X11(regs_q[10]), .X12(regs_q[11]),
    .X13(regs_q[12]), .X14(regs_q[13]), .X15(regs_q[14]), .X16(regs_q[15]),
    .X17(regs_q[16]), .X18(regs_q[17]), .X19(regs_q[18]), .X20(regs_q[19]),
    .X21(regs_q[20]), .X22(regs_q[21]), .X23(regs_q[22]), .X24(regs_q[23]),
    .X25(regs_q[24]), .X26(regs_q[25]), .X27(regs_q[26]), .X28(regs_q[27]),
    .X29(regs_q[28]), .X30(regs_q[29]), .X31(regs_q[30]), .X32(regs_q[31]),
    .Sel(RdAddr2),    .Y  (mux_y2)
  );

  // wr_en is already qualified by RegWrite and never set for x0
  always_comb begin
    byp1    = RST_n && wr_en[RdAddr1] && (WrAddr == RdAddr1);
    byp2    = RST_n && wr_en[RdAddr2] && (WrAddr == RdAddr2);
    RdData1 = byp1 ? WrData : mux_y1;
    RdData2 = byp2 ? WrData : mux_y2;
  end

endmodule

// File: tb/tb_register_file_core.sv
// Self-checking bench for register_file_core: directed table, sweeps, and randomized model comparison.
module tb_register_file_core;

  logic        CLK = 1'b0;
  logic        RST_n, RegWrite;
  logic [4:0]  WrAddr, RdAddr1, RdAddr2;
  logic [31:0] WrData, RdData1, RdData2;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [32];

  register_file_core dut (
    .CLK(CLK), .RST_n(RST_n), .RegWrite(RegWrite), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .RdData1(RdData1), .RdData2(RdData2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        chk;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tab [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, leaving time for combinational outputs to settle.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge CLK);
    RST_n = rst; RegWrite = we; WrAddr = wa; WrData = wd; RdAddr1 = a1; RdAddr2 = a2;
    #1;
  endtask

  // Architectural state update at the clock edge.
  task automatic commit();
    @(posedge CLK);
    if (!RST_n) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (RegWrite && WrAddr != 5'd0) begin
      mem[WrAddr] = WrData;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] ra);
    if (RST_n && RegWrite && WrAddr != 5'd0 && WrAddr == ra) return WrData;
    if (ra == 5'd0) return 32'h0;
    return mem[ra];
  endfunction

  function automatic logic [31:0] sweep_val(input int k);
    return (k == 0) ? 32'h0 : k * 32'h01010101;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    //            rst   we    wa     wd            ra1    ra2    chk   e1            e2
    tab[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b0, 32'h0,        32'h0};
    tab[1]  = '{1'b1, 1'b0, 5'd5,  32'h0,        5'd5,  5'd31, 1'b1, 32'h0,        32'h0};
    tab[2]  = '{1'b1, 1'b1, 5'd7,  32'h12345678, 5'd7,  5'd0,  1'b1, 32'h12345678, 32'h0};
    tab[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b1, 32'h12345678, 32'h0};
    tab[4]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  1'b1, 32'h0,        32'h12345678};
    tab[5]  = '{1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 32'h0,        32'h0};
    tab[6]  = '{1'b1, 1'b1, 5'd3,  32'h11,       5'd3,  5'd7,  1'b1, 32'h11,       32'h12345678};
    tab[7]  = '{1'b1, 1'b1, 5'd3,  32'h22,       5'd3,  5'd3,  1'b1, 32'h22,       32'h22};
    tab[8]  = '{1'b1, 1'b0, 5'd3,  32'h33,       5'd3,  5'd3,  1'b1, 32'h22,       32'h22};
    tab[9]  = '{1'b1, 1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd11, 1'b1, 32'hA5A5A5A5, 32'h0};
    tab[10] = '{1'b0, 1'b1, 5'd11, 32'h5A5A5A5A, 5'd10, 5'd11, 1'b1, 32'hA5A5A5A5, 32'h0};
    tab[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        5'd10, 5'd11, 1'b1, 32'h0,        32'h0};

    for (int v = 0; v < 12; v++) begin
      drive(tab[v].rst_n, tab[v].we, tab[v].wa, tab[v].wd, tab[v].ra1, tab[v].ra2);
      if (tab[v].chk) begin
        check($sformatf("tab%0d_rd1", v), RdData1, tab[v].e1);
        check($sformatf("tab%0d_rd2", v), RdData2, tab[v].e2);
      end
      commit();
    end

    // Everything was cleared by the reset in the table; no register may survive.
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      check($sformatf("zero_sweep_rd1_x%0d", k), RdData1, 32'h0);
      check($sformatf("zero_sweep_rd2_x%0d", 31 - k), RdData2, 32'h0);
      commit();
    end

    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 1'b1, 5'(k), sweep_val(k), 5'd0, 5'd0);
      commit();
    end
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      check($sformatf("pair_rd1_x%0d", k), RdData1, sweep_val(k));
      check($sformatf("pair_rd2_x%0d", 31 - k), RdData2, sweep_val(31 - k));
      commit();
    end

    // Randomized traffic with occasional resets and frequent address collisions.
    for (int n = 0; n < 600; n++) begin
      logic        r, w;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 24) != 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, w, wa, wd, a1, a2);
      check($sformatf("rand%0d_rd1_x%0d", n, a1), RdData1, model_rd(a1));
      check($sformatf("rand%0d_rd2_x%0d", n, a2), RdData2, model_rd(a2));
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
